// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, constants and lane-slicing helper for the systolic feeder
package tpu_pkg;

    localparam int DRAM_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM_X,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    // Returns lane `lane` of a DRAM word, right-aligned; a 64-bit width yields the whole word.
    function automatic logic [DRAM_W-1:0] lane_slice(input logic [DRAM_W-1:0] word,
                                                     input int lane, input int width);
        logic [DRAM_W-1:0] mask;
        mask = (DRAM_W'(1) << width) - DRAM_W'(1);
        return (word >> (lane * width)) & mask;
    endfunction

endpackage

// File: rtl/skew_buffer.sv
// rtl/skew_buffer.sv - per-lane diagonal delay, lane i delayed i cycles, data and valid together
module skew_buffer
    import tpu_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*DATA_W-1:0] data_i,
    input  logic [N-1:0]        valid_i,
    output logic [N*DATA_W-1:0] data_o,
    output logic [N-1:0]        valid_o
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] lane_in;
        assign lane_in = DATA_W'(lane_slice(DRAM_W'(data_i), i, DATA_W));

        if (i == 0) begin : g_pass
            assign data_o[DATA_W-1:0] = lane_in;
            assign valid_o[0]         = valid_i[0];
        end else begin : g_chain
            logic [DATA_W-1:0] data_q [i];
            logic [DATA_W-1:0] data_d [i];
            logic [i-1:0]      valid_q;
            logic [i-1:0]      valid_d;

            always_comb begin
                data_d[0]  = lane_in;
                valid_d[0] = valid_i[i];
                for (int k = 1; k < i; k++) begin
                    data_d[k]  = data_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) data_q[k] <= '0;
                    valid_q <= '0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign data_o[i*DATA_W +: DATA_W] = data_q[i-1];
            assign valid_o[i]                 = valid_q[i-1];
        end
    end

endmodule

// File: rtl/sysray_feeder.sv
// rtl/sysray_feeder.sv - loads one weight tile then streams skewed activations into the array
// Optional stall counter enabled by SYSRAY_FEEDER_STALL_CNT_EN.
module sysray_feeder
    import tpu_pkg::*;
#(
    parameter int N            = 8,
    parameter int DATA_W       = 8,
    parameter int ROWS_W       = 16,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ROWS_W-1:0]   num_rows_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic [63:0]         dram_read_data_i,
    input  logic                dram_read_valid_i,
    output logic                dram_read_ready_o,
    output logic [N*DATA_W-1:0] sysweight_o,
    output logic [N-1:0]        in_valid_weight_o,
    output logic [N*DATA_W-1:0] sysdata_o,
    output logic [N-1:0]        in_valid_input_o,
    output logic [31:0]         stall_cnt_o
);

    localparam int          LANES_W    = N * DATA_W;
    localparam int          WCNT_W     = $clog2(N) + 1;
    localparam logic [31:0] DRAIN_LAST = 32'(N - 1 + DRAIN_CYCLES);

    if (LANES_W != DRAM_W) begin : g_width_check
        $error("sysray_feeder: N*DATA_W must equal 64");
    end

    feeder_state_e       state_q, state_d;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [31:0]         drain_q, drain_d;
    logic                busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic [LANES_W-1:0]  weight_q, weight_d, x_q, x_d;
    logic [N-1:0]        vw_q, vw_d, vx_q, vx_d;
    logic                accept;
    logic                start_take;

    assign accept     = ready_q & dram_read_valid_i;
    assign start_take = (state_q == ST_IDLE) & start_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_i) state_d = ST_LOAD_W;
            ST_LOAD_W:   if (accept && wcnt_q == WCNT_W'(N - 1))
                             state_d = (rows_q == '0) ? ST_DONE : ST_STREAM_X;
            ST_STREAM_X: if (accept && rows_q == ROWS_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN:    if (drain_q == DRAIN_LAST) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so ready/busy/done stay pure functions of state.
    always_comb begin
        rows_d   = rows_q;
        wcnt_d   = wcnt_q;
        if (start_take) begin
            rows_d = num_rows_i;
            wcnt_d = '0;
        end
        if (state_q == ST_LOAD_W && accept)   wcnt_d = wcnt_q + WCNT_W'(1);
        if (state_q == ST_STREAM_X && accept) rows_d = rows_q - ROWS_W'(1);
        drain_d  = (state_q == ST_DRAIN) ? drain_q + 32'd1 : '0;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        ready_d  = (state_d == ST_LOAD_W) || (state_d == ST_STREAM_X);
        weight_d = (state_q == ST_LOAD_W && accept) ? LANES_W'(dram_read_data_i) : '0;
        vw_d     = (state_q == ST_LOAD_W && accept) ? '1 : '0;
        x_d      = (state_q == ST_STREAM_X && accept) ? LANES_W'(dram_read_data_i) : '0;
        vx_d     = (state_q == ST_STREAM_X && accept) ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q   <= '0;
            wcnt_q   <= '0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            weight_q <= '0;
            vw_q     <= '0;
            x_q      <= '0;
            vx_q     <= '0;
        end else begin
            rows_q   <= rows_d;
            wcnt_q   <= wcnt_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            weight_q <= weight_d;
            vw_q     <= vw_d;
            x_q      <= x_d;
            vx_q     <= vx_d;
        end
    end

    skew_buffer #(.N(N), .DATA_W(DATA_W)) u_skew (
        .clk     (clk),
        .rst     (rst),
        .data_i  (x_q),
        .valid_i (vx_q),
        .data_o  (sysdata_o),
        .valid_o (in_valid_input_o)
    );

`ifdef SYSRAY_FEEDER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_take) stall_d = '0;
        else if (ready_q && !dram_read_valid_i && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign dram_read_ready_o = ready_q;
    assign sysweight_o       = weight_q;
    assign in_valid_weight_o = vw_q;

endmodule

// File: tb/tb_sysray_feeder.sv
// tb/tb_sysray_feeder.sv - self-checking bench for sysray_feeder with an event-schedule model
module tb_sysray_feeder;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int D  = 16;
`ifdef SYSRAY_FEEDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [15:0]   num_rows_i;
    logic          busy_o, done_o;
    logic [63:0]   dram_read_data_i;
    logic          dram_read_valid_i;
    logic          dram_read_ready_o;
    logic [63:0]   sysweight_o, sysdata_o;
    logic [N-1:0]  in_valid_weight_o, in_valid_input_o;
    logic [31:0]   stall_cnt_o;

    sysray_feeder #(.N(N), .DATA_W(DW), .ROWS_W(16), .DRAIN_CYCLES(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .num_rows_i        (num_rows_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .dram_read_data_i  (dram_read_data_i),
        .dram_read_valid_i (dram_read_valid_i),
        .dram_read_ready_o (dram_read_ready_o),
        .sysweight_o       (sysweight_o),
        .in_valid_weight_o (in_valid_weight_o),
        .sysdata_o         (sysdata_o),
        .in_valid_input_o  (in_valid_input_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 1'b0;
    int stall_lo = -1, stall_hi = -1;
    bit vx_seen;

    // Model: phase 0 idle, 1 weights, 2 activations; completion is a scheduled cycle.
    int          m_phase = 0, m_rows = 0, m_wcnt = 0, m_rcnt = 0, m_done_at = -1;
    int          mc;
    logic [31:0] exp_stall = 0;
    logic [63:0] exp_w = 0;
    logic [N-1:0] exp_vw = 0;
    logic [7:0]  sched_d [64][N];
    logic        sched_v [64][N];

    function automatic logic [63:0] wword(input int j);
        return 64'h0807060504030201 + 64'(j) * 64'h1010101010101010;
    endfunction

    function automatic logic [63:0] rword(input int k);
        logic [63:0] w;
        for (int i = 0; i < N; i++) w[i*8 +: 8] = {4'(k + 1), 4'(i)};
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        mc = cyc;
        if (rst) begin
            m_phase = 0; m_done_at = -1; exp_stall = 0; exp_w = 0; exp_vw = 0;
            for (int s = 0; s < 64; s++)
                for (int i = 0; i < N; i++) begin sched_d[s][i] = 0; sched_v[s][i] = 0; end
        end else begin
            exp_w = 0; exp_vw = 0;
            if ((m_phase == 1 || m_phase == 2) && !dram_read_valid_i && exp_stall != 32'hffffffff)
                exp_stall = exp_stall + 1;
            if (m_phase == 0 && mc > m_done_at && start_i) begin
                m_phase = 1; m_rows = int'(num_rows_i); m_wcnt = 0; m_rcnt = 0; exp_stall = 0;
            end else if (m_phase == 1 && dram_read_valid_i) begin
                exp_w = dram_read_data_i; exp_vw = '1; m_wcnt++;
                if (m_wcnt == N) begin
                    if (m_rows == 0) begin m_phase = 0; m_done_at = mc + 1; end
                    else m_phase = 2;
                end
            end else if (m_phase == 2 && dram_read_valid_i) begin
                for (int i = 0; i < N; i++) begin
                    sched_d[(mc + 1 + i) % 64][i] = dram_read_data_i[i*8 +: 8];
                    sched_v[(mc + 1 + i) % 64][i] = 1'b1;
                end
                m_rcnt++;
                if (m_rcnt == m_rows) begin m_phase = 0; m_done_at = mc + N + D + 1; end
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (checking) begin
            logic [63:0]  ex;
            logic [N-1:0] ev;
            int s;
            s = cyc % 64;
            for (int i = 0; i < N; i++) begin
                ex[i*8 +: 8] = sched_d[s][i];
                ev[i] = sched_v[s][i];
            end
            chk("busy", busy_o, (m_phase != 0 || cyc <= m_done_at));
            chk("done", done_o, cyc == m_done_at);
            chk("ready", dram_read_ready_o, (m_phase == 1 || m_phase == 2));
            chk("sysweight", sysweight_o, exp_w);
            chk("valid_weight", in_valid_weight_o, exp_vw);
            chk("sysdata", sysdata_o, ex);
            chk("valid_input", in_valid_input_o, ev);
            chk("stall_cnt", stall_cnt_o, STALL_EN ? exp_stall : 32'd0);
            for (int i = 0; i < N; i++) begin sched_d[s][i] = 0; sched_v[s][i] = 0; end
            if (|in_valid_input_o) vx_seen = 1'b1;
        end
    end

    task automatic drive();
        dram_read_valid_i = !(cyc >= stall_lo && cyc <= stall_hi);
        if (m_phase == 1)      dram_read_data_i = wword(m_wcnt);
        else if (m_phase == 2) dram_read_data_i = rword(m_rcnt);
        else                   dram_read_data_i = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic start_run(input int r, output int first);
        start_i = 1'b1;
        num_rows_i = 16'(r);
        first = cyc + 1;
        step();
        start_i = 1'b0;
        num_rows_i = 16'($urandom);
    endtask

    task automatic run_to_done(input string name, input int first, input int exp_lat);
        for (int i = 0; i < 200; i++) begin
            step();
            if (done_o === 1'b1) begin
                chk(name, 64'(cyc - first), 64'(exp_lat));
                return;
            end
        end
        errors++;
        $display("FAIL %s_timeout cyc=%0d got=no_done want=done", name, cyc);
    endtask

    int f;

    initial begin
        rst = 1'b1; start_i = 1'b0; num_rows_i = 0;
        dram_read_valid_i = 1'b1; dram_read_data_i = 0;
        step();
        checking = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", dram_read_ready_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        step();

        // basic run, 3 rows
        start_run(3, f);
        chk("start_busy", busy_o, 1);
        chk("start_ready", dram_read_ready_o, 1);
        step_to(f + 1);
        chk("w0_data", sysweight_o, 64'h0807060504030201);
        chk("w0_valid", in_valid_weight_o, 8'hff);
        step_to(f + 9);
        chk("row0_lane0", sysdata_o[7:0], 8'h10);
        step_to(f + 16);
        chk("row0_lane7", sysdata_o[63:56], 8'h17);
        chk("row0_lane7_v", in_valid_input_o[7], 1);
        run_to_done("basic_latency", f, 35);
        step();

        // two-cycle stall after row 0
        start_run(4, f);
        stall_lo = f + 9; stall_hi = f + 10;
        step_to(f + 12);
        chk("bubble_pre_lane3", in_valid_input_o[3], 1);
        step_to(f + 13);
        chk("bubble_lane3", in_valid_input_o[3], 0);
        run_to_done("stall_latency", f, 38);
        chk("stall_total", stall_cnt_o, STALL_EN ? 32'd2 : 32'd0);
        stall_lo = -1; stall_hi = -1;
        step();

        // zero rows
        vx_seen = 1'b0;
        start_run(0, f);
        run_to_done("zero_latency", f, 8);
        chk("zero_no_vinput", vx_seen, 0);
        step();

        // start while busy is ignored
        start_run(5, f);
        step_to(f + 10);
        start_i = 1'b1; num_rows_i = 16'd2;
        step();
        start_i = 1'b0;
        run_to_done("busy_start_latency", f, 37);
        step();

        // reset during activation row 2
        start_run(4, f);
        step_to(f + 10);
        rst = 1'b1;
        step();
        chk("midrst_busy", busy_o, 0);
        chk("midrst_vinput", in_valid_input_o, 0);
        chk("midrst_data", sysdata_o, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        start_run(2, f);
        run_to_done("post_rst_latency", f, 34);

        // back-to-back start right after done
        step();
        start_run(1, f);
        chk("b2b_busy", busy_o, 1);
        run_to_done("b2b_latency", f, 33);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
